// File: rtl/fp_norm_pipe.sv
// Two-stage leading-one normaliser for the FP add/sub mantissa sum (coarse shift, then fine shift).
// Optional exponent adjust/underflow path is built only when NORM_EXP_ADJ_EN is defined.
module fp_norm_pipe #(
    parameter int WIDTH     = 33,
    parameter int MAX_SHIFT = 26,
    parameter int FINE_W    = 4,
    parameter int EXP_W     = 8,
    localparam int SHIFT_W  = $clog2(MAX_SHIFT + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
`ifdef NORM_EXP_ADJ_EN
    input  logic [EXP_W-1:0]   in_exp,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mant,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_zero
`ifdef NORM_EXP_ADJ_EN
    ,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_uflow
`endif
);

    localparam logic [SHIFT_W-1:0] SHIFT_SAT = SHIFT_W'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] FINE_MASK = SHIFT_W'((1 << FINE_W) - 1);

    if (MAX_SHIFT >= WIDTH || FINE_W < 1 || EXP_W < 1) begin : g_cfg_err
        $error("fp_norm_pipe: illegal parameter combination");
    end

    // Leading-zero count from the MSB, saturated; the highest set bit wins.
    function automatic logic [SHIFT_W-1:0] calc_shift(input logic [WIDTH-1:0] v);
        logic [SHIFT_W-1:0] s;
        logic               found;
        s     = SHIFT_SAT;
        found = 1'b0;
        for (int i = 0; i < MAX_SHIFT; i++) begin
            if (!found && v[WIDTH-1-i]) begin
                s     = SHIFT_W'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return s;
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_mant_q, s1_mant_d;
    logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic               s1_zero_q, s1_zero_d;
    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   s2_mant_q, s2_mant_d;
    logic [SHIFT_W-1:0] s2_shift_q, s2_shift_d;
    logic               s2_zero_q, s2_zero_d;
    logic               s1_adv_s, s2_adv_s;
    logic [SHIFT_W-1:0] in_shift_s;

    // Per-stage advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv_s   = !s2_valid_q || out_ready;
        s1_adv_s   = !s1_valid_q || s2_adv_s;
        in_shift_s = calc_shift(in_sum);
    end

    assign in_ready = s1_adv_s;

    // Stage 1: shift by the coarse part (low FINE_W bits of the shift cleared).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_shift_d = s1_shift_q;
        s1_zero_d  = s1_zero_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_shift_d = in_shift_s;
                s1_zero_d  = (in_sum == {WIDTH{1'b0}});
                s1_mant_d  = in_sum << (in_shift_s & ~FINE_MASK);
            end else begin
                s1_shift_d = s1_shift_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: finish with the fine part of the shift.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mant_d  = s2_mant_q;
        s2_shift_d = s2_shift_q;
        s2_zero_d  = s2_zero_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mant_d  = s1_mant_q << (s1_shift_q & FINE_MASK);
                s2_shift_d = s1_shift_q;
                s2_zero_d  = s1_zero_q;
            end else begin
                s2_shift_d = s2_shift_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_shift_q <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_shift_q <= '0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_shift_q <= s1_shift_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_shift_q <= s2_shift_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_shift = s2_shift_q;
    assign out_zero  = s2_zero_q;

`ifdef NORM_EXP_ADJ_EN
    localparam int CMP_W = ((EXP_W > SHIFT_W) ? EXP_W : SHIFT_W) + 1;

    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic             s2_uflow_q, s2_uflow_d;
    logic [CMP_W-1:0] exp_diff_s;

    // Exponent follows the data; stage 2 subtracts the shift, clamping at zero.
    always_comb begin
        s1_exp_d   = s1_exp_q;
        s2_exp_d   = s2_exp_q;
        s2_uflow_d = s2_uflow_q;
        exp_diff_s = CMP_W'(s1_exp_q) - CMP_W'(s1_shift_q);
        if (s1_adv_s && in_valid) begin
            s1_exp_d = in_exp;
        end else begin
            s1_exp_d = s1_exp_q;
        end
        if (s2_adv_s && s1_valid_q) begin
            if (s1_zero_q) begin
                s2_exp_d   = '0;
                s2_uflow_d = 1'b0;
            end else if (exp_diff_s[CMP_W-1]) begin
                s2_exp_d   = '0;
                s2_uflow_d = 1'b1;
            end else begin
                s2_exp_d   = exp_diff_s[EXP_W-1:0];
                s2_uflow_d = 1'b0;
            end
        end else begin
            s2_exp_d = s2_exp_q;
        end
    end

    // Exponent pipeline registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_exp_q   <= '0;
            s2_exp_q   <= '0;
            s2_uflow_q <= 1'b0;
        end else begin
            s1_exp_q   <= s1_exp_d;
            s2_exp_q   <= s2_exp_d;
            s2_uflow_q <= s2_uflow_d;
        end
    end

    assign out_exp   = s2_exp_q;
    assign out_uflow = s2_uflow_q;
`endif

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Bench for fp_norm_pipe: vector table plus stall/reset sequences, results checked via a scoreboard queue.
module tb_fp_norm_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_sum;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_mant;
    logic [4:0]  out_shift;
    logic        out_zero;
`ifdef NORM_EXP_ADJ_EN
    logic [7:0]  out_exp;
    logic        out_uflow;
`endif

    fp_norm_pipe dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
`ifdef NORM_EXP_ADJ_EN
        .in_exp    (in_exp),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_zero  (out_zero)
`ifdef NORM_EXP_ADJ_EN
        ,
        .out_exp   (out_exp),
        .out_uflow (out_uflow)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [32:0] mant;
        logic [4:0]  shift;
        logic        zero;
        logic [7:0]  exp;
        logic        uflow;
    } res_t;

    typedef struct {
        logic [32:0] sum;
        logic [7:0]  exp;
        res_t        res;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    res_t sb_q[$];
    vec_t vecs[12];
    logic rnd_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: leading zeros from bit 32, capped at 26, whole shift applied at once.
    function automatic res_t model(input logic [32:0] s, input logic [7:0] e);
        res_t r;
        int   lz;
        lz = 33;
        for (int i = 32; i >= 0; i--) begin
            if (s[i] && lz == 33) lz = 32 - i;
        end
        if (lz > 26) lz = 26;
        r.shift = 5'(lz);
        r.mant  = s << lz;
        r.zero  = (s == 33'h0);
        if (r.zero) begin
            r.exp = 8'h0; r.uflow = 1'b0;
        end else if (int'(e) < lz) begin
            r.exp = 8'h0; r.uflow = 1'b1;
        end else begin
            r.exp = 8'(int'(e) - lz); r.uflow = 1'b0;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [32:0] s, input logic [7:0] e, input logic [32:0] m,
                                input logic [4:0] sh, input logic z, input logic [7:0] eo, input logic u);
        vec_t v;
        v.sum = s; v.exp = e;
        v.res.mant = m; v.res.shift = sh; v.res.zero = z; v.res.exp = eo; v.res.uflow = u;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [32:0] s, input logic [7:0] e, input res_t r);
        int n;
        in_valid = 1'b1; in_sum = s; in_exp = e;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd1, 64'd0);
        sb_q.push_back(r);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                res_t r;
                r = sb_q.pop_front();
                chk("mant", 64'(out_mant), 64'(r.mant));
                chk("shift", 64'(out_shift), 64'(r.shift));
                chk("zero", 64'(out_zero), 64'(r.zero));
`ifdef NORM_EXP_ADJ_EN
                chk("exp", 64'(out_exp), 64'(r.exp));
                chk("uflow", 64'(out_uflow), 64'(r.uflow));
`endif
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_left", 64'(sb_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        res_t ra, rb, rc;
        vecs[0]  = mk(33'h1_0000_0000, 8'd20,  33'h1_0000_0000, 5'd0,  1'b0, 8'd20,  1'b0);
        vecs[1]  = mk(33'h0_0000_8000, 8'd20,  33'h1_0000_0000, 5'd17, 1'b0, 8'd3,   1'b0);
        vecs[2]  = mk(33'h0_0000_0008, 8'd20,  33'h0_2000_0000, 5'd26, 1'b0, 8'd0,   1'b1);
        vecs[3]  = mk(33'h0_0000_0000, 8'd20,  33'h0_0000_0000, 5'd26, 1'b1, 8'd0,   1'b0);
        vecs[4]  = mk(33'h0_8000_0000, 8'd20,  33'h1_0000_0000, 5'd1,  1'b0, 8'd19,  1'b0);
        vecs[5]  = mk(33'h1_FFFF_FFFF, 8'd20,  33'h1_FFFF_FFFF, 5'd0,  1'b0, 8'd20,  1'b0);
        vecs[6]  = mk(33'h0_0001_0001, 8'd5,   33'h1_0001_0000, 5'd16, 1'b0, 8'd0,   1'b1);
        vecs[7]  = mk(33'h0_0000_0040, 8'd26,  33'h1_0000_0000, 5'd26, 1'b0, 8'd0,   1'b0);
        vecs[8]  = mk(33'h0_0000_0020, 8'd30,  33'h0_8000_0000, 5'd26, 1'b0, 8'd4,   1'b0);
        vecs[9]  = mk(33'h0_0000_8000, 8'd5,   33'h1_0000_0000, 5'd17, 1'b0, 8'd0,   1'b1);
        vecs[10] = mk(33'h0_0F00_0000, 8'd255, 33'h1_E000_0000, 5'd5,  1'b0, 8'd250, 1'b0);
        vecs[11] = mk(33'h0_0000_7FFF, 8'd18,  33'h1_FFFC_0000, 5'd18, 1'b0, 8'd0,   1'b0);

        RST = 1'b1; in_valid = 1'b0; in_sum = 33'h0; in_exp = 8'h0; out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1;

        // Latency: result visible in the cycle after the second register edge.
        send(vecs[0].sum, vecs[0].exp, vecs[0].res);
        @(negedge CLK);
        chk("lat_early", 64'(out_valid), 64'd0);
        @(negedge CLK);
        chk("lat_valid", 64'(out_valid), 64'd1);
        drain();

        for (int i = 0; i < 12; i++) send(vecs[i].sum, vecs[i].exp, vecs[i].res);
        drain();

        // Stall: A and B fill the pipe, C must wait while A holds at the output.
        ra = vecs[1].res; rb = vecs[4].res; rc = vecs[10].res;
        out_ready = 1'b0;
        send(vecs[1].sum, vecs[1].exp, ra);
        send(vecs[4].sum, vecs[4].exp, rb);
        in_valid = 1'b1; in_sum = vecs[10].sum; in_exp = vecs[10].exp;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_mant", 64'(out_mant), 64'(ra.mant));
            chk("stall_hold_shift", 64'(out_shift), 64'(ra.shift));
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("resume_in_ready", 64'(in_ready), 64'd1);
        chk("order_a", 64'(out_mant), 64'(ra.mant));
        sb_q.push_back(rc);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("order_b_valid", 64'(out_valid), 64'd1);
        chk("order_b", 64'(out_shift), 64'(rb.shift));
        @(negedge CLK);
        chk("order_c_valid", 64'(out_valid), 64'd1);
        chk("order_c", 64'(out_mant), 64'(rc.mant));
        drain();

        // Reset with two results in flight: both are discarded.
        send(vecs[2].sum, vecs[2].exp, vecs[2].res);
        send(vecs[6].sum, vecs[6].exp, vecs[6].res);
        RST = 1'b1;
        sb_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_mant", 64'(out_mant), 64'd0);
        chk("mid_rst_shift", 64'(out_shift), 64'd0);
        chk("mid_rst_zero", 64'(out_zero), 64'd0);
`ifdef NORM_EXP_ADJ_EN
        chk("mid_rst_exp", 64'(out_exp), 64'd0);
        chk("mid_rst_uflow", 64'(out_uflow), 64'd0);
`endif
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge CLK);
        #1;

        // Random sums under random backpressure, checked against the reference model.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [32:0] s;
                    logic [7:0]  e;
                    s = {1'($urandom_range(0, 1)), 32'($urandom)};
                    s = s >> $urandom_range(0, 33);
                    e = 8'($urandom_range(0, 40));
                    send(s, e, model(s, e));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined normaliser for the FP add/sub datapath.
- Takes the unnormalised mantissa sum, including the hidden bit and the guard, round and sticky bits.
- Finds the leading one and left-shifts the sum so the MSB is set.
- Two register stages with valid/ready flow control; feeds rounding and the exponent-adjust logic.

Parameters:
- WIDTH, 33: mantissa sum width, including hidden bit and GRS.
- MAX_SHIFT, 26: saturation limit for the normalisation shift; must be less than WIDTH.
- FINE_W, 4: number of low shift bits applied in stage 2; stage 1 applies shift in multiples of 2^FINE_W.
- EXP_W, 8: exponent width; used only with NORM_EXP_ADJ_EN.
- SHIFT_W (localparam), clog2(MAX_SHIFT+1): width of the shift field; 5 with defaults.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sum valid.
- in_ready  out  1  block can accept an input this cycle.
- in_sum  in  WIDTH  unnormalised mantissa sum.
- in_exp  in  EXP_W  pre-normalisation exponent (NORM_EXP_ADJ_EN only).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  WIDTH  normalised mantissa.
- out_shift  out  SHIFT_W  shift amount applied.
- out_zero  out  1  in_sum was all zero.
- out_exp  out  EXP_W  adjusted exponent (NORM_EXP_ADJ_EN only).
- out_uflow  out  1  exponent underflow (NORM_EXP_ADJ_EN only).

Behaviour:
Shift amount:
- shift = number of leading zeros of in_sum, counted from bit WIDTH-1, saturated at MAX_SHIFT.
- in_sum == 0: shift = MAX_SHIFT and zero = 1.
- Priority: the highest set bit wins.

Stage 1 (registers s1_*):
- Compute shift and zero.
- s1_mant = in_sum << (shift with its low FINE_W bits cleared).
- Register s1_mant, s1_shift, s1_zero and s1_valid.

Stage 2 (registers s2_*, drive the outputs):
- s2_mant = s1_mant << s1_shift[FINE_W-1:0].
- Pass shift and zero through.
- Left shifts fill with 0. Bits shifted past MSB are always 0 because shift ≤ leading-zero count; no data loss.

Handshake (per-stage valid, no skid buffer):
- s2 advances when !s2_valid || out_ready.
- s1 advances when !s1_valid || s2 advances.
- in_ready = s1 advances (combinational from out_ready and the valid registers).
- Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 result per cycle.
- While out_valid && !out_ready, all out_* hold stable.
- Stalled stage registers hold their contents.
- A stage whose predecessor is empty while it advances clears its valid.
- No reordering, no drops, no duplicates; capacity is 2 in flight.

Reset:
- s1_valid, s2_valid, out_valid = 0.
- out_mant, out_shift, out_zero, out_exp, out_uflow = 0.
- Internal data registers = 0.
- Reset mid-stream discards all in-flight data.
- in_ready = 1 in the first cycle after RST deasserts.
- RST dominates any simultaneous transfer.

Optional Feature:
- Macro: NORM_EXP_ADJ_EN.
- Defined:
  - in_exp travels with the data through both stages.
  - Stage 2 computes out_exp = in_exp − shift.
  - If in_exp < shift: out_exp = 0 and out_uflow = 1; otherwise out_uflow = 0.
  - If zero = 1: out_exp = 0 and out_uflow = 0.
- Not defined:
  - in_exp, out_exp and out_uflow are absent from the port list.
  - No exponent registers are built.

Test Plan:
(WIDTH=33, MAX_SHIFT=26, FINE_W=4)
1. in_sum=33'h1_0000_0000, out_ready=1 → 2 cycles later: out_shift=0, out_mant=33'h1_0000_0000, out_zero=0.
2. in_sum=33'h0_0000_8000 (bit 15) → out_shift=17, out_mant=33'h1_0000_0000. Exercises the coarse 16 shift plus a fine 1 shift.
3. in_sum=33'h0_0000_0008 → out_shift=26 (saturated), out_mant=33'h0_2000_0000, out_zero=0. Then in_sum=0 → out_shift=26, out_mant=0, out_zero=1.
4. out_ready=0, three back-to-back inputs A,B,C:
   - in_ready drops after A and B are accepted.
   - out_valid=1 and out_mant stays equal to A's result while stalled.
   - Raise out_ready → A, B, C emerge in order on consecutive cycles.
5. Two inputs in flight, assert RST for 1 cycle → out_valid=0 and all outputs 0 next cycle. No stale result appears afterwards; in_ready=1.
6. NORM_EXP_ADJ_EN:
   - in_sum bit 15, in_exp=8'd20 → out_exp=3, out_uflow=0.
   - in_exp=8'd5 with shift 17 → out_exp=0, out_uflow=1.
